if_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core. It owns the program counter and a direct-mapped instruction cache. On a miss it fetches the word through a single-outstanding-request handshake with the memory controller. Each cycle it presents `if_pc`/`if_inst` to the IF/ID pipeline register, and raises a stall request while no valid instruction is available.

---
 rtl/if_stage_if.sv | 21 ++
 rtl/if_stage.sv | 139 +++++++++++++
 tb/tb_if_stage.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-side memory handshake: single outstanding word request, done pulse returns data.
interface if_stage_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_done_i;
  logic [31:0] mem_inst_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_done_i,
    input  mem_inst_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_done_i,
    output mem_inst_i
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction fetch: PC, direct-mapped one-word-line I-cache, miss fill over if_stage_if.
module if_stage #(
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned TAG_W   = 22
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            stall_i,
  input  logic            b_flag_i,
  input  logic [31:0]     b_target_i,
  if_stage_if.master      mem,
  output logic [31:0]     if_pc,
  output logic [31:0]     if_inst,
  output logic            if_stall_o
);

  localparam int unsigned LINES = 2 ** INDEX_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic              valid_q [LINES];
  logic [TAG_W-1:0]  tag_q   [LINES];
  logic [31:0]       data_q  [LINES];

  logic [INDEX_W-1:0] idx_c;
  logic [TAG_W-1:0]   tag_c;
  logic               hit_c;
  logic [INDEX_W-1:0] fill_idx_c;
  logic [TAG_W-1:0]   fill_tag_c;
  logic               fill_we_c;
  logic [31:0]        redirect_pc_c;

  // Combinational lookup of the current PC
  always_comb begin
    idx_c         = pc_q[INDEX_W+1:2];
    tag_c         = pc_q[31:INDEX_W+2];
    hit_c         = (state_q == IDLE) && valid_q[idx_c] && (tag_q[idx_c] == tag_c);
    fill_idx_c    = mem_addr_q[INDEX_W+1:2];
    fill_tag_c    = mem_addr_q[31:INDEX_W+2];
    redirect_pc_c = b_target_i & 32'hFFFF_FFFC;
  end

  // Next-state: sequential fetch, miss request, fill completion, redirect
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fill_we_c  = 1'b0;

    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (b_flag_i) begin
            pc_d = redirect_pc_c;
          end else if (hit_c) begin
            if (!stall_i) begin
              pc_d = pc_q + 32'd4;
            end
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {pc_q[31:2], 2'b00};
            state_d    = WAIT;
          end
        end
        WAIT: begin
          // An in-flight request cannot be cancelled; the redirect only retargets the PC
          if (b_flag_i) begin
            pc_d      = redirect_pc_c;
            discard_d = 1'b1;
          end
          if (mem.mem_done_i) begin
            fill_we_c = 1'b1;
            mem_req_d = 1'b0;
            discard_d = 1'b0;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= 32'd0;
      discard_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Line valid bits; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (fill_we_c) begin
      valid_q[fill_idx_c] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we_c) begin
      tag_q[fill_idx_c]  <= fill_tag_c;
      data_q[fill_idx_c] <= mem.mem_inst_i;
    end
  end

  always_comb begin
    if_pc          = pc_q;
    if_inst        = hit_c ? data_q[idx_c] : 32'd0;
    if_stall_o     = !hit_c;
    mem.mem_req_o  = mem_req_q;
    mem.mem_addr_o = mem_addr_q;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: address-level cache model, latency-programmable memory responder.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall_i;
  logic        b_flag_i;
  logic [31:0] b_target_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_stall_o;

  if_stage_if mem_bus ();

  if_stage #(.INDEX_W(8), .TAG_W(22)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .stall_i    (stall_i),
    .b_flag_i   (b_flag_i),
    .b_target_i (b_target_i),
    .mem        (mem_bus),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_stall_o (if_stall_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: any address maps to a distinct word; word 0 is addi x0,x0,0
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) | 32'h0000_0013;
  endfunction

  // Model: each cache line remembers the word address last filled into it
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_wait;
  bit          m_req;
  logic [31:0] lines [int];
  bit          presented [logic [31:0]];

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd256);
  endfunction

  function automatic bit m_hit();
    int i;
    i = line_of(m_pc);
    return !m_wait && lines.exists(i) && (lines[i] == m_pc);
  endfunction

  task automatic model_update();
    if (rst) begin
      m_pc   = 32'd0;
      m_addr = 32'd0;
      m_wait = 1'b0;
      m_req  = 1'b0;
      lines.delete();
    end else if (rdy) begin
      if (!m_wait) begin
        if (b_flag_i)       m_pc = b_target_i & 32'hFFFF_FFFC;
        else if (m_hit()) begin
          if (!stall_i)     m_pc = m_pc + 32'd4;
        end else begin
          m_wait = 1'b1;
          m_req  = 1'b1;
          m_addr = m_pc;
        end
      end else begin
        if (mem_bus.mem_done_i) begin
          lines[line_of(m_addr)] = m_addr;
          m_wait = 1'b0;
          m_req  = 1'b0;
        end
        if (b_flag_i) m_pc = b_target_i & 32'hFFFF_FFFC;
      end
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    bit h;
    if (chk_en) begin
      h = m_hit();
      check32("if_pc", if_pc, m_pc);
      check32("if_inst", if_inst, h ? mem_word(m_pc) : 32'd0);
      check32("if_stall_o", 32'(if_stall_o), 32'(!h));
      check32("mem_req_o", 32'(mem_bus.mem_req_o), 32'(m_req));
      check32("mem_addr_o", mem_bus.mem_addr_o, m_addr);
      if (!if_stall_o) presented[if_pc] = 1'b1;
    end
  end

  // Memory responder: done pulses lat cycles after the request rises, never while rdy is low
  bit busy;
  int wait_c;
  int lat;

  task automatic setup(input bit r, input bit s, input bit b, input logic [31:0] t);
    rdy        = r;
    stall_i    = s;
    b_flag_i   = b;
    b_target_i = t;
    if (rst) begin
      busy               = 1'b0;
      mem_bus.mem_done_i = 1'b0;
    end else begin
      if (mem_bus.mem_done_i) begin
        busy               = 1'b0;
        mem_bus.mem_done_i = 1'b0;
      end else if (busy) begin
        wait_c++;
      end
      if (!busy && mem_bus.mem_req_o) begin
        busy   = 1'b1;
        wait_c = 0;
      end
      if (busy && wait_c >= lat && r) begin
        mem_bus.mem_done_i = 1'b1;
        mem_bus.mem_inst_i = mem_word(mem_bus.mem_addr_o);
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc(input bit r, input bit s, input bit b, input logic [31:0] t);
    setup(r, s, b, t);
    edge_step();
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n;
    n = 0;
    while (if_stall_o && n < budget) begin
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      n++;
    end
    check32(name, 32'(if_stall_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst                = 1'b1;
    rdy                = 1'b1;
    stall_i            = 1'b0;
    b_flag_i           = 1'b0;
    b_target_i         = 32'd0;
    mem_bus.mem_done_i = 1'b0;
    mem_bus.mem_inst_i = 32'd0;
    busy               = 1'b0;
    wait_c             = 0;
    lat                = 3;
    m_pc = 32'd0; m_addr = 32'd0; m_wait = 1'b0; m_req = 1'b0;

    // Cold start
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    check32("rst_if_pc", if_pc, 32'd0);
    check32("rst_if_inst", if_inst, 32'd0);
    check32("rst_stall", 32'(if_stall_o), 32'd1);
    check32("rst_req_c0", 32'(mem_bus.mem_req_o), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check32("cold_req_c1", 32'(mem_bus.mem_req_o), 32'd1);
    check32("cold_addr_c1", mem_bus.mem_addr_o, 32'd0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check32("cold_stall_c4", 32'(if_stall_o), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check32("cold_pc_c5", if_pc, 32'd0);
    check32("cold_inst_c5", if_inst, 32'h0000_0013);
    check32("cold_stall_c5", 32'(if_stall_o), 32'd0);

    // Warm loop: reach 0xC, redirect to 0, refetch hits one per cycle
    n = 0;
    while (!(if_pc == 32'hC && !if_stall_o) && n < 60) begin
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      n++;
    end
    check32("warm_reach_pc", if_pc, 32'hC);
    check32("warm_reach_stall", 32'(if_stall_o), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check32("warm_pc", if_pc, 32'(4 * k));
      check32("warm_stall", 32'(if_stall_o), 32'd0);
      check32("warm_noreq", 32'(mem_bus.mem_req_o), 32'd0);
      check32("warm_inst", if_inst, 32'((4 * k) << 8) | 32'h13);
      if (k < 3) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    end

    // Redirect during WAIT
    lat = 4;
    cyc(1'b1, 1'b0, 1'b1, 32'h40);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check32("rw_req", 32'(mem_bus.mem_req_o), 32'd1);
    check32("rw_addr", mem_bus.mem_addr_o, 32'h40);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 32'h103);
    n = 0;
    while (mem_bus.mem_req_o && n < 20) begin
      check32("rw_addr_held", mem_bus.mem_addr_o, 32'h40);
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      n++;
    end
    check32("rw_req_dropped", 32'(mem_bus.mem_req_o), 32'd0);
    check32("rw_newpc", if_pc, 32'h100);
    check32("rw_newpc_stall", 32'(if_stall_o), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check32("rw_next_addr", mem_bus.mem_addr_o, 32'h100);
    wait_ready("rw_ready", 20);
    check32("rw_ready_pc", if_pc, 32'h100);
    check32("rw_never_0x40", 32'(presented.exists(32'h40)), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 32'h40);
    check32("rw_0x40_filled", 32'(if_stall_o), 32'd0);
    check32("rw_0x40_inst", if_inst, 32'h0000_4013);

    // Stall held on a hit at 0x8
    cyc(1'b1, 1'b0, 1'b1, 32'h8);
    for (int k = 0; k < 3; k++) begin
      check32("stall_pc", if_pc, 32'h8);
      check32("stall_inst", if_inst, 32'h0000_0813);
      cyc(1'b1, 1'b1, 1'b0, 32'd0);
    end
    check32("stall_release_pc", if_pc, 32'h8);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check32("stall_advance_pc", if_pc, 32'hC);

    // Conflict eviction, then rdy low in WAIT
    lat = 2;
    cyc(1'b1, 1'b0, 1'b1, 32'h400);
    wait_ready("conf_ready", 20);
    check32("conf_inst", if_inst, 32'h0004_0013);
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    check32("conf_evicted", 32'(if_stall_o), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check32("conf_req", 32'(mem_bus.mem_req_o), 32'd1);
    check32("conf_addr", mem_bus.mem_addr_o, 32'd0);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 32'h200);
      check32("rdy_req_held", 32'(mem_bus.mem_req_o), 32'd1);
      check32("rdy_addr_held", mem_bus.mem_addr_o, 32'd0);
      check32("rdy_pc_held", if_pc, 32'd0);
    end
    wait_ready("rdy_ready", 20);
    check32("rdy_ready_pc", if_pc, 32'd0);

    // Redirect coinciding with done, then PC wrap
    cyc(1'b1, 1'b0, 1'b1, 32'h800);
    n = 0;
    while (n < 20) begin
      setup(1'b1, 1'b0, 1'b0, 32'd0);
      if (mem_bus.mem_done_i) begin
        b_flag_i   = 1'b1;
        b_target_i = 32'hFFFF_FFFE;
        n          = 100;
      end else begin
        n++;
      end
      edge_step();
    end
    check32("bd_pc", if_pc, 32'hFFFF_FFFC);
    check32("bd_req", 32'(mem_bus.mem_req_o), 32'd0);
    wait_ready("bd_ready", 20);
    check32("bd_inst", if_inst, 32'hFFFF_FC13);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check32("wrap_pc", if_pc, 32'd0);
    check32("wrap_miss", 32'(if_stall_o), 32'd1);
    wait_ready("wrap_ready", 20);
    check32("wrap_inst", if_inst, 32'h0000_0013);

    // Reset while a request is outstanding
    cyc(1'b1, 1'b0, 1'b1, 32'h1000);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check32("rstw_req", 32'(mem_bus.mem_req_o), 32'd1);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    check32("rstw_req_clr", 32'(mem_bus.mem_req_o), 32'd0);
    check32("rstw_pc", if_pc, 32'd0);
    check32("rstw_cache_clr", 32'(if_stall_o), 32'd1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'd0);

    chk_en = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
